// File: rtl/gci_std_display_vram_read_scheduler.sv
// Display-side VRAM read sequencer: burst reads into a pixel FIFO, pops on pixel request, frame flush and underflow.
// Optional macro GCI_STD_DISPLAY_VRAM_READ_UNDERFLOW_CNT_EN adds the saturating oUNDERFLOW_CNT output.
module gci_std_display_vram_read_scheduler #(
  parameter int P_MEM_ADDR_N = 23,
  parameter int P_BASE_ADDR  = 0,
  parameter int P_H_PIXELS   = 640,
  parameter int P_V_LINES    = 480,
  parameter int P_BURST_LEN  = 16,
  parameter int P_FIFO_DEPTH = 64
) (
  input  logic                    iDISP_CLOCK,
  input  logic                    inRESET,
  input  logic                    iRESET_SYNC,
  input  logic                    iRD_ENA,
  input  logic                    iRD_SYNC,
  output logic                    oRD_VALID,
  output logic [9:0]              oRD_DATA_R,
  output logic [9:0]              oRD_DATA_G,
  output logic [9:0]              oRD_DATA_B,
  output logic                    oUNDERFLOW,
  output logic                    oIF_REQ,
  input  logic                    iIF_ACK,
  output logic                    oIF_FINISH,
  output logic                    oIF_ENA,
  input  logic                    iIF_BUSY,
  output logic [P_MEM_ADDR_N-1:0] oIF_ADDR,
  input  logic                    iIF_VALID,
  input  logic [31:0]             iIF_DATA
`ifdef GCI_STD_DISPLAY_VRAM_READ_UNDERFLOW_CNT_EN
  ,
  output logic [15:0]             oUNDERFLOW_CNT
`endif
);

  localparam int L_PW = $clog2(P_FIFO_DEPTH);
  localparam int L_CW = L_PW + 1;
  localparam int L_BW = $clog2(P_BURST_LEN) + 1;
  localparam logic [P_MEM_ADDR_N-1:0] L_BASE = P_MEM_ADDR_N'(P_BASE_ADDR);
  localparam logic [P_MEM_ADDR_N-1:0] L_LAST = P_MEM_ADDR_N'(P_BASE_ADDR + P_H_PIXELS * P_V_LINES - 1);
  localparam logic [L_BW-1:0] L_BURST    = L_BW'(P_BURST_LEN);
  localparam logic [L_BW-1:0] L_BURST_M1 = L_BW'(P_BURST_LEN - 1);
  localparam logic [L_CW-1:0] L_ROOM     = L_CW'(P_FIFO_DEPTH - P_BURST_LEN);

  typedef enum logic [2:0] {ST_IDLE, ST_REQ, ST_ISSUE, ST_WAIT, ST_FIN} state_t;

  state_t                  r_state, w_next;
  logic [P_MEM_ADDR_N-1:0] r_addr;
  logic [L_BW-1:0]         r_issued, r_recv;
  logic                    r_pending;
  logic [L_CW-1:0]         r_count;
  logic [L_PW-1:0]         r_wptr, r_rptr;
  logic [31:0]             r_mem [P_FIFO_DEPTH];
  logic                    r_rd_valid;
  logic [29:0]             r_rd_data;
  logic                    r_underflow;

  logic            w_in_burst, w_accept, w_flush, w_set_pending, w_push;
  logic            w_rd_req, w_pop, w_uflow;
  logic [L_BW-1:0] w_outstanding;
  logic [L_CW-1:0] w_reserved;
  logic            w_unused_data;

  assign w_unused_data = &{1'b0, iIF_DATA[31:30]};

  assign w_in_burst    = (r_state == ST_ISSUE) || (r_state == ST_WAIT);
  assign w_accept      = (r_state == ST_ISSUE) && !iIF_BUSY;
  // Outside a burst a frame sync clears at once; inside one it is deferred to FIN.
  assign w_flush       = (iRD_SYNC && !w_in_burst) || ((r_state == ST_FIN) && r_pending);
  assign w_set_pending = iRD_SYNC && w_in_burst;
  assign w_push        = iIF_VALID && w_in_burst && !r_pending && !w_set_pending;
  assign w_rd_req      = iRD_ENA && !iRD_SYNC && !r_pending;
  assign w_pop         = w_rd_req && (r_count != '0);
  assign w_uflow       = w_rd_req && (r_count == '0);
  assign w_outstanding = r_issued - r_recv;
  assign w_reserved    = r_count + L_CW'(w_outstanding);

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (!r_pending && !iRD_SYNC && (w_reserved <= L_ROOM)) w_next = ST_REQ;
      ST_REQ:   if (iIF_ACK) w_next = ST_ISSUE;
      ST_ISSUE: if (w_accept && (r_issued == L_BURST_M1)) w_next = ST_WAIT;
      ST_WAIT:  if ((r_recv == L_BURST) || (iIF_VALID && (r_recv == L_BURST_M1))) w_next = ST_FIN;
      ST_FIN:   w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  assign oIF_REQ    = (r_state == ST_REQ);
  assign oIF_ENA    = (r_state == ST_ISSUE);
  assign oIF_ADDR   = (r_state == ST_ISSUE) ? r_addr : '0;
  assign oIF_FINISH = (r_state == ST_FIN);
  assign oRD_VALID  = r_rd_valid;
  assign oRD_DATA_R = r_rd_data[29:20];
  assign oRD_DATA_G = r_rd_data[19:10];
  assign oRD_DATA_B = r_rd_data[9:0];
  assign oUNDERFLOW = r_underflow;

  always_ff @(posedge iDISP_CLOCK) begin
    if (w_push) r_mem[r_wptr] <= iIF_DATA;
  end

  always_ff @(posedge iDISP_CLOCK or negedge inRESET) begin
    if (!inRESET) begin
      r_state <= ST_IDLE;  r_addr <= L_BASE;  r_issued <= '0;  r_recv <= '0;
      r_pending <= 1'b0;   r_count <= '0;     r_wptr <= '0;    r_rptr <= '0;
      r_rd_valid <= 1'b0;  r_rd_data <= '0;   r_underflow <= 1'b0;
    end else if (iRESET_SYNC) begin
      r_state <= ST_IDLE;  r_addr <= L_BASE;  r_issued <= '0;  r_recv <= '0;
      r_pending <= 1'b0;   r_count <= '0;     r_wptr <= '0;    r_rptr <= '0;
      r_rd_valid <= 1'b0;  r_rd_data <= '0;   r_underflow <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_flush) r_addr <= L_BASE;
      else if (w_accept) r_addr <= (r_addr == L_LAST) ? L_BASE : r_addr + P_MEM_ADDR_N'(1);
      if (r_state == ST_FIN) begin
        r_issued  <= '0;
        r_recv    <= '0;
        r_pending <= 1'b0;
      end else begin
        if (w_accept) r_issued <= r_issued + L_BW'(1);
        if (iIF_VALID && w_in_burst) r_recv <= r_recv + L_BW'(1);
        if (w_set_pending) r_pending <= 1'b1;
      end
      if (w_flush) begin
        r_count <= '0;
        r_wptr  <= '0;
        r_rptr  <= '0;
      end else begin
        if (w_push) r_wptr <= r_wptr + L_PW'(1);
        if (w_pop)  r_rptr <= r_rptr + L_PW'(1);
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + L_CW'(1);
          2'b01:   r_count <= r_count - L_CW'(1);
          default: r_count <= r_count;
        endcase
      end
      r_rd_valid <= w_pop;
      r_rd_data  <= w_pop ? r_mem[r_rptr][29:0] : '0;
      if (w_uflow) r_underflow <= 1'b1;
    end
  end

`ifdef GCI_STD_DISPLAY_VRAM_READ_UNDERFLOW_CNT_EN
  logic [15:0] r_uf_cnt;
  always_ff @(posedge iDISP_CLOCK or negedge inRESET) begin
    if (!inRESET) r_uf_cnt <= '0;
    else if (iRESET_SYNC) r_uf_cnt <= '0;
    else if (w_uflow && (r_uf_cnt != 16'hFFFF)) r_uf_cnt <= r_uf_cnt + 16'd1;
  end
  assign oUNDERFLOW_CNT = r_uf_cnt;
`endif

endmodule

// File: doc/gci_std_display_vram_read_scheduler.md
Name: gci_std_display_vram_read_scheduler

Overview:
- Display-side VRAM read sequencer. Keeps an internal pixel FIFO filled by issuing fixed-length read bursts on the VRAM interface-arbiter IF0 port (REQ/ACK/ENA/BUSY/VALID/FINISH).
- Feeds pixels to the display output latch on demand from the timing generator's data request/sync.
- Owns the frame address counter, frame-start flush and underflow detection.

Parameters:
- P_MEM_ADDR_N, 23: VRAM word-address width.
- P_BASE_ADDR, 0: frame buffer base word address.
- P_H_PIXELS, 640: pixels per line.
- P_V_LINES, 480: lines per frame.
- P_BURST_LEN, 16: words per read burst; power of two, at least 2.
- P_FIFO_DEPTH, 64: pixel FIFO depth in words; power of two, at least 2*P_BURST_LEN.

Ports:
- iDISP_CLOCK  in  1  display clock; all logic on rising edge.
- inRESET  in  1  asynchronous active-low reset.
- iRESET_SYNC  in  1  synchronous reset; same effect as inRESET.
- iRD_ENA  in  1  pixel request from the timing generator.
- iRD_SYNC  in  1  frame-start pulse (one cycle).
- oRD_VALID  out  1  oRD_DATA_* valid.
- oRD_DATA_R  out  10  red, from word bits 29:20.
- oRD_DATA_G  out  10  green, from word bits 19:10.
- oRD_DATA_B  out  10  blue, from word bits 9:0.
- oUNDERFLOW  out  1  sticky underflow flag.
- oIF_REQ  out  1  arbitration request.
- iIF_ACK  in  1  arbitration grant.
- oIF_FINISH  out  1  one-cycle pulse releasing the arbiter.
- oIF_ENA  out  1  read command strobe.
- iIF_BUSY  in  1  command stall.
- oIF_ADDR  out  P_MEM_ADDR_N  read word address.
- iIF_VALID  in  1  read data strobe.
- iIF_DATA  in  32  read data word.

Behaviour:
- Reset (inRESET low or iRESET_SYNC high):
  - All outputs 0.
  - FIFO empty; outstanding count 0.
  - Frame address = P_BASE_ADDR; state IDLE.
- Reserved count = FIFO occupancy + words commanded but not yet returned.
- FSM, one burst at a time:
  - IDLE: go to REQ when flush is not pending and P_FIFO_DEPTH − reserved ≥ P_BURST_LEN.
  - REQ: oIF_REQ=1, held until iIF_ACK=1; then go to ISSUE.
  - ISSUE: oIF_ENA=1 with oIF_ADDR = current address.
    - A command is accepted in a cycle where oIF_ENA=1 and iIF_BUSY=0; on acceptance, address advances and the issued count increments.
    - When iIF_BUSY=1, oIF_ENA and oIF_ADDR hold.
    - After P_BURST_LEN accepted commands, go to WAIT.
  - WAIT: stay until all P_BURST_LEN VALID words have arrived; then go to FIN.
  - FIN: oIF_FINISH=1 for one cycle; go to IDLE.
  - REQ stays low from ACK until IDLE.
- Address arithmetic:
  - Advances by 1 per accepted command.
  - After address P_BASE_ADDR + P_H_PIXELS*P_V_LINES − 1, wraps to P_BASE_ADDR.
  - A burst may straddle the wrap.
- Data path:
  - Each iIF_VALID pushes iIF_DATA into the FIFO. Overflow is impossible by the reservation rule.
  - Simultaneous push and pop in one cycle is legal; occupancy is unchanged.
- Read side:
  - iRD_ENA with FIFO non-empty: pop, and one cycle later oRD_VALID=1 with the word's R/G/B.
  - iRD_ENA with FIFO empty: next cycle oRD_VALID=0, data=0, and oUNDERFLOW set.
  - Cycles without iRD_ENA: oRD_VALID=0 and data=0.
  - oUNDERFLOW clears only on reset.
- iRD_SYNC:
  - If the FSM is in IDLE, or enters REQ in the same cycle: FIFO cleared and address reset to P_BASE_ADDR on that edge; FSM stays/returns IDLE.
  - If a burst is in ISSUE or WAIT: flush is pending.
    - The current burst completes its handshake.
    - Its returned data is discarded; no push.
    - At FIN: FIFO cleared, address reset, pending cleared.
  - While flush is pending, iRD_ENA returns oRD_VALID=0 with data 0 and does not set oUNDERFLOW.
  - A second iRD_SYNC while pending has no additional effect.
- iRD_ENA and iRD_SYNC in the same cycle: sync wins; no pop, no underflow.

Optional Feature:
- Macro: GCI_STD_DISPLAY_VRAM_READ_UNDERFLOW_CNT_EN.
- Defined:
  - Adds output oUNDERFLOW_CNT, 16 bits: count of empty-FIFO iRD_ENA cycles.
  - Saturates at 16'hFFFF; reset to 0.
  - iRD_SYNC does not clear it.
- Undefined: port and counter absent; only the sticky oUNDERFLOW flag exists.

Test Plan:
- Reset check: after inRESET release with ACK held 0 → oIF_REQ=1 on the first cycle after reset and stays 1; all other outputs 0.
- First burst, defaults: ACK after 3 cycles, BUSY=0 → 16 ENA cycles with oIF_ADDR 0..15; return 16 VALID words 0x3FF00000+i → one oIF_FINISH pulse, then a new REQ. After 4 bursts, with no reads and the FIFO at 64, REQ stays low.
- BUSY stall: iIF_BUSY=1 for 5 cycles on the 3rd command → oIF_ENA and oIF_ADDR=2 held for 5 cycles; total accepted commands stay 16.
- Underflow: iRD_ENA with FIFO empty → oRD_VALID=0 and oUNDERFLOW=1 next cycle; with the macro defined, 3 such cycles give count 3.
- Wrap: P_H_PIXELS=4, P_V_LINES=2, P_BURST_LEN=4, P_FIFO_DEPTH=8, P_BASE_ADDR=0x10 → addresses 0x10..0x17, then 0x10.
- Sync mid-burst: iRD_SYNC during WAIT after 2 of 16 VALIDs → remaining VALIDs not pushed; after FINISH the FIFO is empty and the next burst starts at P_BASE_ADDR; iRD_ENA during pending gives no underflow.
